// File: rtl/elm_pkg.sv
// Shared ELM layer definitions: loader FSM states and default weight memory geometry.
package elm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ADDR_WIDTH = 10;

endpackage

// File: rtl/weight_mem_loader_if.sv
// AXI-Stream channel carrying weight words into the weight memory loader.
interface weight_mem_loader_if
    import elm_pkg::*;
#(
    parameter int unsigned dataWidth = DATA_WIDTH
) ();

    logic [dataWidth-1:0] tdata;
    logic                 tvalid;
    logic                 tlast;
    logic                 tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/weight_mem_loader_addr_gen.sv
// Address/neuron counters for the weight loader; flags the last word of the layer.
module weight_addr_gen #(
    parameter int unsigned neuronNo     = 34,
    parameter int unsigned numWeight    = 784,
    parameter int unsigned addressWidth = 10,
    parameter int unsigned neuronWidth  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    advance,
    output logic [addressWidth-1:0] addr_cnt,
    output logic [neuronWidth-1:0]  neuron_cnt,
    output logic                    last_beat
);

    localparam logic [addressWidth-1:0] LAST_ADDR   = addressWidth'(numWeight - 1);
    localparam logic [neuronWidth-1:0]  LAST_NEURON = neuronWidth'(neuronNo - 1);

    logic [addressWidth-1:0] addr_cnt_q, addr_cnt_d;
    logic [neuronWidth-1:0]  neuron_cnt_q, neuron_cnt_d;

    always_comb begin
        addr_cnt_d   = addr_cnt_q;
        neuron_cnt_d = neuron_cnt_q;
        if (clear) begin
            addr_cnt_d   = '0;
            neuron_cnt_d = '0;
        end else if (advance) begin
            // Wrap on the configured depth, not the address space size.
            if (addr_cnt_q == LAST_ADDR) begin
                addr_cnt_d   = '0;
                neuron_cnt_d = neuron_cnt_q + neuronWidth'(1);
            end else begin
                addr_cnt_d = addr_cnt_q + addressWidth'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt_q   <= '0;
            neuron_cnt_q <= '0;
        end else begin
            addr_cnt_q   <= addr_cnt_d;
            neuron_cnt_q <= neuron_cnt_d;
        end
    end

    assign addr_cnt   = addr_cnt_q;
    assign neuron_cnt = neuron_cnt_q;
    assign last_beat  = (addr_cnt_q == LAST_ADDR) && (neuron_cnt_q == LAST_NEURON);

endmodule

// File: rtl/weight_mem_loader.sv
// Streams weight words into per-neuron memories with a one-hot write enable.
// Optional WEIGHT_LOADER_CHECKSUM_EN adds a running modulo sum of written words.
module weight_mem_loader
    import elm_pkg::*;
#(
    parameter int unsigned neuronNo     = 34,
    parameter int unsigned numWeight    = 784,
    parameter int unsigned addressWidth = ADDR_WIDTH,
    parameter int unsigned dataWidth    = DATA_WIDTH,
    parameter int unsigned neuronWidth  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    weight_mem_loader_if.slave       s_axis,
    output logic [neuronNo-1:0]      wen,
    output logic [addressWidth-1:0]  waddr,
    output logic [dataWidth-1:0]     wdata,
    output logic                     busy,
    output logic                     done,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    output logic                     err,
    output logic [dataWidth-1:0]     checksum
`else
    output logic                     err
`endif
);

    load_state_t             state_q, state_d;
    logic                    tready_q, tready_d;
    logic                    err_q, err_d;
    logic [neuronNo-1:0]     wen_q, wen_d;
    logic [addressWidth-1:0] waddr_q, waddr_d;
    logic [dataWidth-1:0]    wdata_q, wdata_d;

    logic                    beat;
    logic                    clear_cnt;
    logic                    last_beat;
    logic [addressWidth-1:0] addr_cnt;
    logic [neuronWidth-1:0]  neuron_cnt;

    assign beat      = s_axis.tvalid & tready_q;
    assign clear_cnt = (state_q == ST_IDLE) & start;

    weight_addr_gen #(
        .neuronNo     (neuronNo),
        .numWeight    (numWeight),
        .addressWidth (addressWidth),
        .neuronWidth  (neuronWidth)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_cnt),
        .advance    (beat),
        .addr_cnt   (addr_cnt),
        .neuron_cnt (neuron_cnt),
        .last_beat  (last_beat)
    );

    always_comb begin
        state_d  = state_q;
        tready_d = 1'b0;
        err_d    = err_q;
        wen_d    = '0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    tready_d = 1'b1;
                    err_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                tready_d = 1'b1;
                if (beat) begin
                    for (int unsigned i = 0; i < neuronNo; i++) begin
                        wen_d[i] = (neuron_cnt == neuronWidth'(i));
                    end
                    waddr_d = addr_cnt;
                    wdata_d = s_axis.tdata;
                    // Framing is good only when tlast lands exactly on the last word.
                    if (last_beat || s_axis.tlast) begin
                        state_d  = ST_DONE;
                        tready_d = 1'b0;
                        err_d    = err_q | (last_beat ^ s_axis.tlast);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tready_q <= 1'b0;
            err_q    <= 1'b0;
            wen_q    <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
            err_q    <= err_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign s_axis.tready = tready_q;
    assign wen           = wen_q;
    assign waddr         = waddr_q;
    assign wdata         = wdata_q;
    assign busy          = (state_q == ST_LOAD);
    assign done          = (state_q == ST_DONE);
    assign err           = err_q;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [dataWidth-1:0] sum_q, sum_d;

    // Accumulating on the beat makes the sum land in the same cycle as its wen.
    always_comb begin
        sum_d = sum_q;
        if (clear_cnt) begin
            sum_d = '0;
        end else if (beat) begin
            sum_d = sum_q + s_axis.tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_weight_mem_loader.sv
// Scoreboard bench for weight_mem_loader: randomized streams against a word-index memory model.
`timescale 1ns/1ps
module tb_weight_mem_loader;

    localparam int NN    = 3;
    localparam int NW    = 4;
    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int NWID  = 2;
    localparam int TOTAL = NN * NW;

    typedef struct {
        int            n;
        int            a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        logic          err;
        logic [DW-1:0] sum;
    } done_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NN-1:0] wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic          err;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    weight_mem_loader_if #(.dataWidth(DW)) bus ();

    weight_mem_loader #(
        .neuronNo     (NN),
        .numWeight    (NW),
        .addressWidth (AW),
        .dataWidth    (DW),
        .neuronWidth  (NWID)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_axis   (bus.slave),
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        .err      (err),
        .checksum (checksum)
`else
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    wr_t   exp_q[$];
    done_t done_q[$];

    logic [DW-1:0] model_mem [NN][NW];
    logic [DW-1:0] dut_mem   [NN][NW];
    bit            exp_ready = 1'b0;
    bit            exp_err   = 1'b0;
    int            k         = 0;
    logic [DW-1:0] exp_sum   = '0;

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: the k-th accepted word goes to neuron k/NW, address k%NW.
    task automatic accept(input logic [DW-1:0] d, input logic last);
        wr_t w;
        w.n = k / NW;
        w.a = k % NW;
        w.d = d;
        exp_q.push_back(w);
        model_mem[w.n][w.a] = d;
        exp_sum = exp_sum + d;
        k++;
        if (last || k == TOTAL) begin
            exp_ready = 1'b0;
            exp_err   = (last != (k == TOTAL));
            done_q.push_back('{exp_err, exp_sum});
        end
    endtask

    task automatic cycle_checks();
        check("tready", int'(bus.tready), int'(exp_ready));
        check("busy", int'(busy), int'(exp_ready));
        check("err", int'(err), int'(exp_err));
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        check("checksum_running", int'(checksum), int'(exp_sum));
`endif
    endtask

    // Called 1ns after a rising edge; returns 1ns after the next one.
    task automatic offer(input logic [DW-1:0] d, input logic last, input logic valid);
        logic rdy;
        bus.tdata  = d;
        bus.tlast  = last;
        bus.tvalid = valid;
        @(negedge clk);
        cycle_checks();
        rdy = bus.tready;
        @(posedge clk);
        if (valid && rdy && exp_ready) accept(d, last);
        #1;
    endtask

    task automatic do_start();
        start      = 1'b1;
        bus.tvalid = 1'b0;
        @(negedge clk);
        cycle_checks();
        @(posedge clk);
        #1;
        start     = 1'b0;
        exp_ready = 1'b1;
        exp_err   = 1'b0;
        exp_sum   = '0;
        k         = 0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < 10) begin
            offer(DW'($urandom), 1'b0, 1'b0);
            n++;
        end
        check({tag, "_pending_events"}, exp_q.size() + done_q.size(), 0);
        repeat (2) offer(DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < NN; i++)
            for (int j = 0; j < NW; j++)
                check($sformatf("%s_mem[%0d][%0d]", tag, i, j), int'(dut_mem[i][j]), int'(model_mem[i][j]));
    endtask

    // Monitor: pops expected writes / done events whenever the DUT shows them.
    int            last_a   = 0;
    logic [DW-1:0] last_d   = '0;
    bit            rst_pend = 1'b0;
    int            mon_idx;

    always @(negedge clk) begin
        wr_t   e;
        done_t de;
        if (rst_pend) begin
            last_a = 0;
            last_d = '0;
        end
        if (wen != '0) begin
            check("wen_onehot", $countones(wen), 1);
            mon_idx = -1;
            for (int i = 0; i < NN; i++) if (wen[i]) mon_idx = i;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got wen=%b waddr=%0d wdata=%0d, expected no write (t=%0t)",
                         wen, waddr, wdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("wen_neuron", mon_idx, e.n);
                check("waddr", int'(waddr), e.a);
                check("wdata", int'(wdata), int'(e.d));
            end
            if (mon_idx >= 0 && int'(waddr) < NW) dut_mem[mon_idx][waddr] = wdata;
            last_a = int'(waddr);
            last_d = wdata;
        end else if (!rst && !rst_pend) begin
            check("waddr_hold", int'(waddr), last_a);
            check("wdata_hold", int'(wdata), int'(last_d));
        end
        if (done) begin
            check("done_with_wen", int'(wen != '0), 1);
            if (done_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected done=0 (t=%0t)", $time);
            end else begin
                de = done_q.pop_front();
                check("done_err", int'(err), int'(de.err));
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                check("done_checksum", int'(checksum), int'(de.sum));
`endif
            end
        end
        rst_pend = rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int pos;
        for (int i = 0; i < NN; i++)
            for (int j = 0; j < NW; j++) begin
                model_mem[i][j] = '0;
                dut_mem[i][j]   = '0;
            end
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
        bus.tdata  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wen", int'(wen), 0);
        check("rst_waddr", int'(waddr), 0);
        check("rst_wdata", int'(wdata), 0);
        check("rst_done", int'(done), 0);
        cycle_checks();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back 1..12 with tlast on the final word
        do_start();
        for (int i = 1; i <= TOTAL; i++) offer(DW'(i), i == TOTAL, 1'b1);
        drain("t1");

        // Same stream with idle cycles between beats
        do_start();
        for (int i = 1; i <= TOTAL; i++) begin
            offer(DW'(i), i == TOTAL, 1'b1);
            offer(DW'($urandom), 1'b0, 1'b0);
        end
        drain("t2");

        // Early tlast on beat 6
        do_start();
        for (int i = 1; i <= TOTAL; i++) offer(DW'($urandom), i == 6, 1'b1);
        drain("t3");

        // No tlast; a 13th word must be refused
        do_start();
        for (int i = 1; i <= TOTAL + 1; i++) offer(DW'($urandom), 1'b0, 1'b1);
        drain("t4");

        // Reset after beat 5, then a fresh full load
        do_start();
        for (int i = 1; i <= 5; i++) offer(DW'($urandom), 1'b0, 1'b1);
        rst        = 1'b1;
        bus.tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        exp_sum   = '0;
        k         = 0;
        @(negedge clk);
        check("midrst_wen", int'(wen), 0);
        check("midrst_waddr", int'(waddr), 0);
        check("midrst_wdata", int'(wdata), 0);
        check("midrst_done", int'(done), 0);
        cycle_checks();
        @(posedge clk);
        #1;
        drain("t5a");
        do_start();
        for (int i = 1; i <= TOTAL; i++) offer(DW'($urandom), i == TOTAL, 1'b1);
        drain("t5b");

        // Random valid gaps with a random tlast position (beyond TOTAL means none)
        for (int t = 0; t < 4; t++) begin
            pos = int'($urandom_range(1, TOTAL + 2));
            do_start();
            cyc = 0;
            while (exp_ready && cyc < 80) begin
                offer(DW'($urandom), (k + 1) == pos, $urandom_range(0, 3) != 0);
                cyc++;
            end
            check("rand_load_finished", int'(exp_ready), 0);
            drain($sformatf("r%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
